// File: rtl/fetch_unit_if.sv
// Instruction-memory channel between the fetch stage and instruction memory:
// a valid/ready request carrying the fetch address, plus an unthrottled
// response carrying the instruction word.
interface fetch_unit_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  ireq_ready,
        input  iresp_valid,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output ireq_ready,
        output iresp_valid,
        output iresp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, keeps one instruction-memory request
// outstanding at most, and buffers the returned word for decode as
// {instruction, pc_plus_4}. Branch redirects from execute override every
// other event and turn any in-flight fetch into a stale one that is dropped.
//
// state  | meaning
// S_REQ  | request for pc presented on the memory channel
// S_WAIT | request accepted, waiting for its response
// S_FULL | f_d_reg holds a valid instruction, waiting for decode
// S_KILL | outstanding response is wrong-path, drop it when it arrives
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              d_ready,
    output logic              f_valid,
    output logic [63:0]       f_d_reg
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_KILL = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_4;
    } f_d_reg_t;

    state_t      state;
    logic [31:0] pc;
    f_d_reg_t    f_d_q;
    logic [31:0] pc_plus_4;

    assign pc_plus_4 = pc + 32'd4;

    // The request is decoded from the registered state; gating with reset keeps
    // memory from seeing a request while the fetch stage is held in reset.
    assign imem.ireq_valid = (state == S_REQ) && reset;
    assign imem.ireq_addr  = pc;
    assign f_d_reg         = f_d_q;

    // Fetch sequencer: PC, buffer and state advance together; redirect wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            f_valid <= 1'b0;
            f_d_q   <= '0;
        end else if (redirect) begin
            pc      <= {redirect_pc[31:2], 2'b00};
            f_valid <= 1'b0;
            case (state)
                // An address accepted this very cycle still owes us a response.
                S_REQ:   state <= imem.ireq_ready ? S_KILL : S_REQ;
                S_WAIT:  state <= imem.iresp_valid ? S_REQ : S_KILL;
                S_FULL:  state <= S_REQ;
                S_KILL:  state <= imem.iresp_valid ? S_REQ : S_KILL;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.ireq_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.iresp_valid) begin
                        f_d_q.instruction <= imem.iresp_data;
                        f_d_q.pc_plus_4   <= pc_plus_4;
                        f_valid           <= 1'b1;
                        pc                <= pc_plus_4;
                        state             <= S_FULL;
                    end
                end
                S_FULL: begin
                    // Contents are left in place; only the valid flag drops.
                    if (d_ready) begin
                        f_valid <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (imem.iresp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for the fetch stage: drives the memory channel by hand, keeps its own
// PC model, and queues expected {instruction, pc_plus_4} words when a live
// response is sent, popping them when f_valid shows up.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_ready;
    logic        f_valid;
    logic [63:0] f_d_reg;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_ready     (d_ready),
        .f_valid     (f_valid),
        .f_d_reg     (f_d_reg)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          outstanding = 0;
    logic [31:0] exp_pc;
    logic [63:0] sb_q[$];

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol watch: a response must always match an accepted request.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding = 0;
        end else begin
            if (bus.iresp_valid) begin
                compared++;
                if (outstanding == 0) begin
                    mismatched++;
                    $display("FAIL proto_resp: response with %0d outstanding, required >= 1", outstanding);
                end else begin
                    outstanding--;
                end
            end
            if (bus.ireq_valid && bus.ireq_ready) begin
                outstanding++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bus.ireq_ready = 1'b1;
        step();
        bus.ireq_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input bit live);
        bus.iresp_data  = data;
        bus.iresp_valid = 1'b1;
        if (live) begin
            sb_q.push_back({data, exp_pc + 32'd4});
        end
        step();
        bus.iresp_valid = 1'b0;
        if (live) begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic wait_fvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (f_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        step();
        compared++;
        if (bus.ireq_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_ireq_valid: got %b required 0", bus.ireq_valid);
        end
        compared++;
        if (f_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_f_valid: got %b required 0", f_valid);
        end
        compared++;
        if (f_d_reg !== 64'd0) begin
            mismatched++;
            $display("FAIL rst_f_d_reg: got %h required 0", f_d_reg);
        end
        compared++;
        if (bus.ireq_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL rst_pc: got %h required %h", bus.ireq_addr, RESET_PC);
        end
        reset  = 1'b1;
        exp_pc = RESET_PC;
        #1;
        compared++;
        if (bus.ireq_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_release_req: got %b required 1", bus.ireq_valid);
        end
    endtask

    task automatic test_basic_fetch();
        logic [63:0] exp;
        bit ok;
        compared++;
        if (bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL basic_addr: got %h required %h", bus.ireq_addr, exp_pc);
        end
        accept();
        compared++;
        if (bus.ireq_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_wait_noreq: got %b required 0", bus.ireq_valid);
        end
        respond(32'h2008_0005, 1'b1);
        compared++;
        if (f_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_latency: f_valid got %b required 1", f_valid);
        end
        wait_fvalid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL basic_timeout: f_valid got 0 required 1");
        end else begin
            exp = sb_q.pop_front();
            compared++;
            if (f_d_reg !== exp) begin
                mismatched++;
                $display("FAIL basic_f_d_reg: got %h required %h", f_d_reg, exp);
            end
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        compared++;
        if (f_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_consume: f_valid got %b required 0", f_valid);
        end
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL basic_next_req: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        bit ok;
        accept();
        respond(32'h8C22_0004, 1'b1);
        wait_fvalid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL stall_timeout: f_valid got 0 required 1");
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (f_d_reg !== exp || f_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h required valid=1 data=%h",
                         i, f_valid, f_d_reg, exp);
            end
            compared++;
            if (bus.ireq_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_noreq[%0d]: got %b required 0", i, bus.ireq_valid);
            end
            step();
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        compared++;
        if (f_valid !== 1'b0 || f_d_reg !== exp) begin
            mismatched++;
            $display("FAIL stall_release: got valid=%b data=%h required valid=0 data=%h",
                     f_valid, f_d_reg, exp);
        end
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL stall_next_req: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
    endtask

    task automatic test_redirect_wait();
        logic [63:0] exp;
        bit ok;
        accept();
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect = 1'b0;
        exp_pc   = 32'h8000_0100;
        step();
        respond(32'hDEAD_BEEF, 1'b0);
        compared++;
        if (f_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rdw_drop: f_valid got %b required 0", f_valid);
        end
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL rdw_refetch: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
        accept();
        respond(32'h0000_1025, 1'b1);
        wait_fvalid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL rdw_timeout: f_valid got 0 required 1");
        end else begin
            exp = sb_q.pop_front();
            compared++;
            if (f_d_reg !== exp) begin
                mismatched++;
                $display("FAIL rdw_f_d_reg: got %h required %h", f_d_reg, exp);
            end
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
    endtask

    task automatic test_redirect_handshake();
        bus.ireq_ready = 1'b1;
        redirect       = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        bus.ireq_ready = 1'b0;
        redirect       = 1'b0;
        exp_pc         = 32'h8000_0200;
        compared++;
        if (bus.ireq_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rdh_kill_noreq: got %b required 0", bus.ireq_valid);
        end
        step();
        respond(32'h1234_5678, 1'b0);
        compared++;
        if (f_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rdh_drop: f_valid got %b required 0", f_valid);
        end
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL rdh_refetch: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
    endtask

    task automatic test_redirect_full();
        logic [63:0] exp;
        bit ok;
        accept();
        respond(32'h2402_000A, 1'b1);
        wait_fvalid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL rdf_timeout: f_valid got 0 required 1");
        end else begin
            exp = sb_q.pop_front();
            compared++;
            if (f_d_reg !== exp) begin
                mismatched++;
                $display("FAIL rdf_f_d_reg: got %h required %h", f_d_reg, exp);
            end
        end
        d_ready     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0303;
        step();
        d_ready  = 1'b0;
        redirect = 1'b0;
        exp_pc   = 32'h8000_0300;
        compared++;
        if (f_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rdf_flush: f_valid got %b required 0", f_valid);
        end
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL rdf_refetch: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [63:0] exp;
        bit ok;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        exp_pc   = 32'hFFFF_FFFC;
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== exp_pc) begin
            mismatched++;
            $display("FAIL wrap_req: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, exp_pc);
        end
        accept();
        respond(32'h0000_0000, 1'b1);
        wait_fvalid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL wrap_timeout: f_valid got 0 required 1");
        end else begin
            exp = sb_q.pop_front();
            compared++;
            if (f_d_reg !== exp) begin
                mismatched++;
                $display("FAIL wrap_f_d_reg: got %h required %h", f_d_reg, exp);
            end
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h0000_0000) begin
            mismatched++;
            $display("FAIL wrap_next_req: got valid=%b addr=%h required valid=1 addr=00000000",
                     bus.ireq_valid, bus.ireq_addr);
        end
        accept();
        reset = 1'b0;
        #1;
        compared++;
        if (f_valid !== 1'b0 || bus.ireq_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_immediate: got f_valid=%b ireq_valid=%b required 0/0",
                     f_valid, bus.ireq_valid);
        end
        step();
        reset  = 1'b1;
        exp_pc = RESET_PC;
        #1;
        compared++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL midrst_release: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.ireq_valid, bus.ireq_addr, RESET_PC);
        end
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
        end
    endtask

    // Scenario sequence.
    initial begin
        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        d_ready         = 1'b0;
        bus.ireq_ready  = 1'b0;
        bus.iresp_valid = 1'b0;
        bus.iresp_data  = 32'd0;
        exp_pc          = RESET_PC;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_redirect_full();
        test_wrap_and_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
